// File: rtl/sclk_countdown_timer.sv
// Synchronises the divided clock sclk, turns its edges into single-cycle ticks
// and runs a loadable countdown timer (IDLE/RUN/PAUSE/DONE) driven by those ticks.
module sclk_countdown_timer #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned EDGE_MODE   = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sclk,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             start,
  input  logic             stop,
  output logic             tick,
  output logic [WIDTH-1:0] count,
  output logic             running,
  output logic             expired,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   tick_q;
  logic                   edge_det;
  logic                   sync_last;

  state_t                 state_q, state_d;
  logic [WIDTH-1:0]       count_q, count_d;
  logic                   done_q;

  assign sync_last = sync_q[SYNC_STAGES-1];
  assign edge_det  = (EDGE_MODE != 0) ? (sync_last ^ hist_q) : (sync_last & ~hist_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      hist_q <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sclk};
      hist_q <= sync_last;
      tick_q <= edge_det;
    end
  end

  // Priority load > stop > start; a tick that empties the counter beats stop.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    if (load) begin
      count_d = load_value;
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) state_d = (count_q != '0) ? RUN : DONE;
        end
        RUN: begin
          if (tick_q && (count_q != '0)) count_d = count_q - WIDTH'(1);
          if ((tick_q && (count_q <= WIDTH'(1))) || (count_q == '0)) state_d = DONE;
          else if (stop)                                                 state_d = PAUSE;
        end
        PAUSE: begin
          if (start) state_d = RUN;
        end
        DONE: begin
          count_d = '0;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      done_q  <= (state_d == DONE) && (state_q != DONE);
    end
  end

  assign tick    = tick_q;
  assign count   = count_q;
  assign running = (state_q == RUN);
  assign expired = (state_q == DONE);
  assign done    = done_q;

endmodule

// File: tb/tb_sclk_countdown_timer.sv
// Directed-vector bench: a default instance plus an EDGE_MODE=1 instance share
// all inputs; sclk is stepped by hand in 8-clk half periods.
module tb_sclk_countdown_timer;

  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         sclk = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_value = '0;
  logic         start = 1'b0;
  logic         stop = 1'b0;

  logic         tick0, running0, expired0, done0;
  logic [W-1:0] count0;
  logic         tick1, running1, expired1, done1;
  logic [W-1:0] count1;

  int vecs = 0;
  int errs = 0;
  int cyc = 0;
  int ticks0, ticks1, dones0, consec;
  int tick_times[$];

  always #5 clk = ~clk;

  sclk_countdown_timer #(.WIDTH(W), .SYNC_STAGES(2), .EDGE_MODE(0)) dut0 (
    .clk(clk), .reset(reset), .sclk(sclk), .load(load), .load_value(load_value),
    .start(start), .stop(stop), .tick(tick0), .count(count0),
    .running(running0), .expired(expired0), .done(done0)
  );

  sclk_countdown_timer #(.WIDTH(W), .SYNC_STAGES(2), .EDGE_MODE(1)) dut1 (
    .clk(clk), .reset(reset), .sclk(sclk), .load(load), .load_value(load_value),
    .start(start), .stop(stop), .tick(tick1), .count(count1),
    .running(running1), .expired(expired1), .done(done1)
  );

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic clear_stats();
    ticks0 = 0; ticks1 = 0; dones0 = 0; consec = 0;
    tick_times.delete();
  endtask

  task automatic half_period();
    logic prev;
    prev = tick0;
    sclk = ~sclk;
    repeat (8) begin
      step();
      if (tick0) begin ticks0++; tick_times.push_back(cyc); end
      if (tick1) ticks1++;
      if (done0) dones0++;
      if (tick0 && prev) consec++;
      prev = tick0;
    end
  endtask

  task automatic period();
    half_period();
    half_period();
  endtask

  task automatic do_load(input logic [W-1:0] v);
    load = 1'b1; load_value = v; step(); load = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    vecs++; if (count0 !== 16'h0 || tick0 !== 1'b0 || running0 !== 1'b0 || expired0 !== 1'b0 || done0 !== 1'b0) begin
      $display("FAIL reset_init: count=%0h tick=%b run=%b exp=%b done=%b, required all 0", count0, tick0, running0, expired0, done0); errs++; end
    step(); step();
    reset = 1'b0;
    step();
    do_load(16'd7);
    do_start();
    vecs++; if (running0 !== 1'b1 || count0 !== 16'd7) begin
      $display("FAIL reset_prerun: run=%b count=%0d, required 1 / 7", running0, count0); errs++; end
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    vecs++; if (count0 !== 16'h0 || tick0 !== 1'b0 || running0 !== 1'b0 || expired0 !== 1'b0 || done0 !== 1'b0) begin
      $display("FAIL reset_async: count=%0h tick=%b run=%b exp=%b done=%b, required all 0", count0, tick0, running0, expired0, done0); errs++; end
    step();
    reset = 1'b0;
    clear_stats();
    period(); period();
    vecs++; if (count0 !== 16'h0 || running0 !== 1'b0 || dones0 !== 0) begin
      $display("FAIL reset_idle_after: count=%0d run=%b dones=%0d, required 0/0/0", count0, running0, dones0); errs++; end
    vecs++; if (ticks0 !== 2) begin
      $display("FAIL reset_ticks_still: ticks=%0d, required 2", ticks0); errs++; end
  endtask

  task automatic test_tick();
    logic [3:0] seen0, seen1;
    sclk = 1'b1;
    for (int i = 0; i < 4; i++) begin step(); seen0[i] = tick0; seen1[i] = tick1; end
    vecs++; if (seen0 !== 4'b0100) begin
      $display("FAIL tick_latency_rise: pattern=%b, required 0100", seen0); errs++; end
    vecs++; if (seen1 !== 4'b0100) begin
      $display("FAIL tick_latency_rise_both: pattern=%b, required 0100", seen1); errs++; end
    repeat (4) step();
    sclk = 1'b0;
    for (int i = 0; i < 4; i++) begin step(); seen0[i] = tick0; seen1[i] = tick1; end
    vecs++; if (seen0 !== 4'b0000 || seen1 !== 4'b0100) begin
      $display("FAIL tick_fall: rise_only=%b both=%b, required 0000 / 0100", seen0, seen1); errs++; end
    repeat (4) step();
    clear_stats();
    repeat (4) period();
    vecs++; if (ticks0 !== 4 || ticks1 !== 8) begin
      $display("FAIL tick_count: rise_only=%0d both=%0d, required 4 / 8", ticks0, ticks1); errs++; end
    vecs++; if (consec !== 0) begin
      $display("FAIL tick_consecutive: got %0d double-cycle ticks, required 0", consec); errs++; end
    for (int i = 1; i < tick_times.size(); i++) begin
      vecs++; if (tick_times[i] - tick_times[i-1] !== 16) begin
        $display("FAIL tick_spacing: got %0d, required 16", tick_times[i] - tick_times[i-1]); errs++; end
    end
  endtask

  task automatic test_countdown();
    logic [W-1:0] exp_cnt [3] = '{16'd2, 16'd1, 16'd0};
    do_load(16'd3);
    vecs++; if (count0 !== 16'd3 || running0 !== 1'b0) begin
      $display("FAIL cd_load: count=%0d run=%b, required 3 / 0", count0, running0); errs++; end
    do_start();
    clear_stats();
    for (int i = 0; i < 3; i++) begin
      period();
      vecs++; if (count0 !== exp_cnt[i]) begin
        $display("FAIL cd_step%0d: count=%0d, required %0d", i, count0, exp_cnt[i]); errs++; end
    end
    vecs++; if (expired0 !== 1'b1 || running0 !== 1'b0 || dones0 !== 1) begin
      $display("FAIL cd_done: exp=%b run=%b dones=%0d, required 1/0/1", expired0, running0, dones0); errs++; end
    clear_stats();
    start = 1'b1; stop = 1'b1;
    period(); period();
    start = 1'b0; stop = 1'b0;
    vecs++; if (count0 !== 16'd0 || expired0 !== 1'b1 || dones0 !== 0) begin
      $display("FAIL cd_hold: count=%0d exp=%b dones=%0d, required 0/1/0", count0, expired0, dones0); errs++; end
  endtask

  task automatic test_pause();
    do_load(16'd5);
    do_start();
    stop = 1'b1; step(); stop = 1'b0;
    vecs++; if (running0 !== 1'b0 || count0 !== 16'd5) begin
      $display("FAIL pause_enter: run=%b count=%0d, required 0 / 5", running0, count0); errs++; end
    clear_stats();
    stop = 1'b1;
    repeat (4) period();
    stop = 1'b0;
    vecs++; if (count0 !== 16'd5 || ticks0 !== 4) begin
      $display("FAIL pause_hold: count=%0d ticks=%0d, required 5 / 4", count0, ticks0); errs++; end
    do_start();
    vecs++; if (running0 !== 1'b1) begin
      $display("FAIL pause_resume: run=%b, required 1", running0); errs++; end
    period();
    vecs++; if (count0 !== 16'd4) begin
      $display("FAIL pause_next_tick: count=%0d, required 4", count0); errs++; end
    start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
    vecs++; if (running0 !== 1'b0 || expired0 !== 1'b0 || count0 !== 16'd4) begin
      $display("FAIL pause_start_stop: run=%b exp=%b count=%0d, required 0/0/4", running0, expired0, count0); errs++; end
  endtask

  task automatic test_simultaneous();
    do_load(16'd1);
    do_start();
    sclk = 1'b1;
    step(); step(); step();
    vecs++; if (tick0 !== 1'b1 || running0 !== 1'b1) begin
      $display("FAIL simul_setup: tick=%b run=%b, required 1 / 1", tick0, running0); errs++; end
    stop = 1'b1; step(); stop = 1'b0;
    vecs++; if (count0 !== 16'd0 || expired0 !== 1'b1 || done0 !== 1'b1 || running0 !== 1'b0) begin
      $display("FAIL simul_tick_stop: count=%0d exp=%b done=%b run=%b, required 0/1/1/0", count0, expired0, done0, running0); errs++; end
    do_load(16'd9);
    vecs++; if (count0 !== 16'd9 || expired0 !== 1'b0 || done0 !== 1'b0 || running0 !== 1'b0) begin
      $display("FAIL simul_load_done: count=%0d exp=%b done=%b run=%b, required 9/0/0/0", count0, expired0, done0, running0); errs++; end
    repeat (3) step();
    half_period();
  endtask

  task automatic test_edges();
    do_load(16'd0);
    do_start();
    vecs++; if (expired0 !== 1'b1 || done0 !== 1'b1) begin
      $display("FAIL edge_zero_start: exp=%b done=%b, required 1 / 1", expired0, done0); errs++; end
    step();
    vecs++; if (done0 !== 1'b0 || expired0 !== 1'b1) begin
      $display("FAIL edge_done_width: done=%b exp=%b, required 0 / 1", done0, expired0); errs++; end
    do_load(16'hFFFF);
    do_start();
    period();
    vecs++; if (count0 !== 16'hFFFE) begin
      $display("FAIL edge_max_rise: count=%0h, required fffe", count0); errs++; end
    vecs++; if (count1 !== 16'hFFFD) begin
      $display("FAIL edge_max_both: count=%0h, required fffd", count1); errs++; end
  endtask

  initial begin
    clear_stats();
    test_reset();
    test_tick();
    test_countdown();
    test_pause();
    test_simultaneous();
    test_edges();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sclk_countdown_timer.md
# sclk_countdown_timer

Consumes the slow divided clock `sclk` produced by the upstream clock divider and turns it into system-clock-domain events. It synchronises `sclk`, emits a one-cycle `tick` per `sclk` edge, and runs a loadable countdown timer that decrements on each tick. The timer has start, stop and load controls and reports run, expiry and done status. It sits directly downstream of the divider and feeds software-visible timeout logic.

## Interface
- `WIDTH`, 16: countdown register width (2..32).
- `SYNC_STAGES`, 2: synchroniser flop count on `sclk` (>= 2).
- `EDGE_MODE`, 0: 0 = tick on `sclk` rising edges only; 1 = tick on both edges.

- `clk`  in  1  system clock, the same clock that drives the divider.
- `reset`  in  1  asynchronous, active-high reset. The block has one clock; this reset polarity and its asynchronous behaviour are fixed.
- `sclk`  in  1  divided clock from upstream, treated as asynchronous data.
- `load`  in  1  one-cycle strobe that loads `load_value` into the counter.
- `load_value`  in  WIDTH  countdown start value.
- `start`  in  1  one-cycle strobe that starts or resumes counting.
- `stop`  in  1  one-cycle strobe that pauses counting.
- `tick`  out  1  one-cycle pulse per detected `sclk` edge.
- `count`  out  WIDTH  current countdown value.
- `running`  out  1  high while the FSM is in RUN.
- `expired`  out  1  high while the FSM is in DONE.
- `done`  out  1  one-cycle pulse on entry to DONE.

## Operation
- **Synchroniser:** `sclk` passes through `SYNC_STAGES` flops, then one history flop. The edge condition is `sync_last & ~hist` (rising), or `sync_last ^ hist` when `EDGE_MODE`=1. `tick` is registered from the edge condition.
- **Tick independence:** `tick` is produced in every FSM state. Ticks outside RUN are discarded and never queued.
- **FSM states:** IDLE, RUN, PAUSE, DONE. Control priority is `load` > `stop` > `start`.
- **load, any state:**
  - `count` <= `load_value`; FSM -> IDLE.
  - `expired` clears; `done` is not asserted.
- **IDLE:**
  - `start` with `count` != 0 -> RUN.
  - `start` with `count` == 0 -> DONE (`done` pulses).
  - `stop` is ignored.
- **RUN:**
  - On each `tick`, `count` <= `count` - 1.
  - A `tick` with `count` == 1 sets `count` to 0, moves to DONE and pulses `done`.
  - `stop` -> PAUSE.
  - `tick` and `stop` in the same cycle: the decrement is applied, then PAUSE. If that decrement reaches 0, DONE wins over PAUSE.
  - `start` and `stop` in the same cycle: PAUSE.
- **PAUSE:** `count` is held. `start` -> RUN; `stop` is ignored.
- **DONE:** `count` = 0 and `expired` = 1. `start` and `stop` are ignored; only `load` exits.
- **Arithmetic:** `count` never underflows; decrement happens only when `count` >= 1. `load_value` = 0 is legal and leads to the immediate-DONE case above.
- **Reset, including mid-operation:** all flops clear immediately and asynchronously. `count` = 0, FSM = IDLE, and synchroniser and history flops = 0. Release of `reset` is assumed synchronous to `clk` by the system reset controller.

## Timing
- **Reset values:** `tick`=0, `count`=0, `running`=0, `expired`=0, `done`=0.
- **Tick latency:** if `sclk` is first sampled high at `clk` edge k, `tick` is high for the one cycle following edge k+`SYNC_STAGES`. It is never high for two consecutive cycles.
- **Minimum `sclk` level width:** 2 `clk` periods for correct edge detection. Narrower pulses may be missed, and must never produce more than one tick per edge.
- **Control strobes:** take effect at the next `clk` edge. `running` and `expired` follow the FSM state register with no added latency.
- **Decrement latency:** `count` updates on the edge that samples `tick` high, i.e. 1 cycle after `tick` rises.
- **`done` latency:** high for exactly one cycle, the first cycle in which `expired` is high.
- **`reset` during RUN:** no `done` pulse is generated.

## Test plan
- **Reset:** assert `reset` mid-RUN with `count`=7 -> all outputs 0 within the same cycle; after release, the FSM is in IDLE and further `sclk` edges decrement nothing.
- **Tick generation:**
  - Setup: `SYNC_STAGES`=2, `EDGE_MODE`=0, `sclk` toggling every 8 `clk`.
  - Rising edge sampled at edge k -> single-cycle `tick` after edge k+2.
  - Rising-edge ticks are 16 `clk` apart; no tick is produced on falling edges.
- **Full countdown:** `load` with `load_value`=3, then `start` -> `count` steps 3, 2, 1, 0 on successive ticks; `done` pulses once; `expired` stays 1; further ticks leave `count` at 0.
- **Pause/resume:** `count`=5 in RUN.
  - `stop` -> `count` holds 5 across 4 ticks.
  - `start` -> resumes, and the next tick gives 4.
  - `start` and `stop` in the same cycle -> PAUSE.
- **Simultaneous events:**
  - `tick` and `stop` in the same cycle at `count`=1 -> `count` 0, DONE, `done` pulse.
  - `load`=9 during DONE -> IDLE, `count`=9, `expired`=0.
- **Edge cases:**
  - `load_value`=0 then `start` -> DONE on the next edge with a `done` pulse.
  - `EDGE_MODE`=1 -> 2 ticks per `sclk` period.
  - `WIDTH`=16, `load_value`=16'hFFFF -> first tick gives 16'hFFFE.
